// File: rtl/bsg_segment_assembler_pkg.sv
// Shared types and elaboration-time helpers for the segment assembler.
//   state_e      : assembler FSM states (fill / full)
//   safe_clog2   : clog2 that never returns 0 (used for the segment id width)
//   seg_offset   : bit offset of segment k inside the wide word
//   width_sum    : total width of the first n segments
// Segment widths are handed to the helpers as a flat 32-bit-per-entry vector
// so that a single function signature serves every els_p.
package bsg_segment_assembler_pkg;

    localparam int max_els_lp = 64;

    typedef enum logic {e_fill, e_full} state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int seg_offset(input logic [max_els_lp*32-1:0] widths, input int k);
        int s;
        s = 0;
        for (int j = 0; j < max_els_lp; j++)
            if (j < k) s += int'(widths[j*32 +: 32]);
        return s;
    endfunction

    function automatic int width_sum(input logic [max_els_lp*32-1:0] widths, input int n);
        return seg_offset(widths, n);
    endfunction

endpackage

// File: rtl/bsg_segment_assembler_mask.sv
// Fill-tracking mask for the segment assembler.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   set              : one-hot (or zero) bits to mark written this cycle
//   clear            : drop every bit (word consumed); wins over set
//   mask             : registered written-segment vector
//   done             : (mask | set) covers exactly the required segments,
//                      i.e. the word is complete after this edge
module bsg_segment_assembler_mask #(
    parameter int                els_p = 1,
    parameter logic [els_p-1:0]  req_p = '1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [els_p-1:0] set,
    input  logic             clear,
    output logic [els_p-1:0] mask,
    output logic             done
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            mask <= '0;
        else if (clear)
            mask <= '0;
        else
            mask <= mask | set;
    end

    assign done = ((mask | set) == req_p);

endmodule

// File: rtl/bsg_segment_assembler.sv
// Segment assembler: collects narrow segment writes into one wide word for a
// segmented enable register and hands the completed word to a consumer.
// Ports:
//   clk_i, reset_n_i  : clock, asynchronous active-low reset
//   v_i, ready_and_o  : segment write handshake (fire = v_i & ready_and_o)
//   seg_id_i, data_i  : target segment and its LSB-aligned data
//   en_o, data_o      : per-segment enable and broadcast wide data
//   written_o         : segments written since the last clear
//   v_o, yumi_i       : word-complete handshake to the consumer
// Optional build macro BSG_SEGMENT_ASSEMBLER_DUP_STALL_EN: a write to an
// already-filled segment is stalled instead of overwriting it.
module bsg_segment_assembler
    import bsg_segment_assembler_pkg::*;
#(
    parameter int               els_p       = 3,
    parameter int               widths_p [els_p-1:0] = '{12, 4, 8},
    parameter int               width_sum_p = 24,
    parameter logic [els_p-1:0] skip_p      = '0,
    parameter int               max_width_p = 12,
    parameter int               id_width_p  = safe_clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [id_width_p-1:0]  seg_id_i,
    input  logic [max_width_p-1:0] data_i,
    output logic                   ready_and_o,
    output logic [els_p-1:0]       en_o,
    output logic [width_sum_p-1:0] data_o,
    output logic [els_p-1:0]       written_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    function automatic logic [max_els_lp*32-1:0] pack_widths();
        logic [max_els_lp*32-1:0] r;
        r = '0;
        for (int k = 0; k < els_p; k++) r[k*32 +: 32] = widths_p[k];
        return r;
    endfunction

    localparam logic [max_els_lp*32-1:0] widths_flat_lp = pack_widths();
    localparam logic [els_p-1:0]         req_lp         = ~skip_p;

    if (els_p > max_els_lp) begin : g_bad_els
        $error("bsg_segment_assembler: els_p exceeds max_els_lp");
    end
    if (width_sum_p != width_sum(widths_flat_lp, els_p)) begin : g_bad_sum
        $error("bsg_segment_assembler: width_sum_p does not match sum of widths_p");
    end

    state_e           state;
    logic             v_r;
    logic             rdy_r;
    logic             fire;
    logic             done;
    logic             clear;
    logic [els_p-1:0] sel;
    logic [els_p-1:0] mask;

    // Decode seg_id_i per segment; ids >= els_p simply match nothing, which
    // makes out-of-range writes fall out as accepted-and-discarded.
    for (genvar k = 0; k < els_p; k++) begin : g_seg
        localparam int off_lp = seg_offset(widths_flat_lp, k);
        localparam int w_lp   = widths_p[k];

        if (w_lp > max_width_p) begin : g_bad_w
            $error("bsg_segment_assembler: widths_p entry exceeds max_width_p");
        end

        assign data_o[off_lp +: w_lp] = data_i[w_lp-1:0];
        assign sel[k] = (seg_id_i == id_width_p'(k));
    end

`ifdef BSG_SEGMENT_ASSEMBLER_DUP_STALL_EN
    // Hold off a rewrite of a filled segment until the word is consumed.
    logic dup;
    assign dup         = v_i & |(sel & mask);
    assign ready_and_o = rdy_r & ~dup;
`else
    assign ready_and_o = rdy_r;
`endif

    assign fire      = v_i & ready_and_o;
    assign en_o      = fire ? (sel & ~skip_p) : '0;
    assign clear     = (state == e_full) & yumi_i;
    assign written_o = mask;
    assign v_o       = v_r;

    bsg_segment_assembler_mask #(
        .els_p (els_p),
        .req_p (req_lp)
    ) u_mask (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .set       (en_o),
        .clear     (clear),
        .mask      (mask),
        .done      (done)
    );

    // rdy_r stays low through reset and comes up on the first edge after
    // release; with nothing required, that same edge goes straight to FULL.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= e_fill;
            v_r   <= 1'b0;
            rdy_r <= 1'b0;
        end else begin
            case (state)
                e_fill: begin
                    if (done) begin
                        state <= e_full;
                        v_r   <= 1'b1;
                        rdy_r <= 1'b0;
                    end else begin
                        rdy_r <= 1'b1;
                    end
                end
                e_full: begin
                    if (yumi_i) begin
                        state <= e_fill;
                        v_r   <= 1'b0;
                        rdy_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_segment_assembler.sv
module tb_bsg_segment_assembler;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    always #5 clk_i = ~clk_i;

    // main instance (no skips)
    logic        v_i, yumi_i, ready_and_o, v_o;
    logic [1:0]  seg_id_i;
    logic [11:0] data_i;
    logic [2:0]  en_o, written_o;
    logic [23:0] data_o;

    // skip_p = 3'b010 instance
    logic        s_v, s_yumi, s_ready, s_vo;
    logic [1:0]  s_id;
    logic [11:0] s_data;
    logic [2:0]  s_en, s_written;
    logic [23:0] s_data_o;

    // all-skipped instance
    logic        a_ready, a_vo;
    logic [2:0]  a_en, a_written;
    logic [23:0] a_data_o;

    bsg_segment_assembler #(.els_p(3), .widths_p('{12, 4, 8}), .width_sum_p(24),
                            .max_width_p(12)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .seg_id_i(seg_id_i),
        .data_i(data_i), .ready_and_o(ready_and_o), .en_o(en_o), .data_o(data_o),
        .written_o(written_o), .v_o(v_o), .yumi_i(yumi_i));

    bsg_segment_assembler #(.els_p(3), .widths_p('{12, 4, 8}), .width_sum_p(24),
                            .skip_p(3'b010), .max_width_p(12)) u_skip (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(s_v), .seg_id_i(s_id),
        .data_i(s_data), .ready_and_o(s_ready), .en_o(s_en), .data_o(s_data_o),
        .written_o(s_written), .v_o(s_vo), .yumi_i(s_yumi));

    bsg_segment_assembler #(.els_p(3), .widths_p('{12, 4, 8}), .width_sum_p(24),
                            .skip_p(3'b111), .max_width_p(12)) u_all (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(1'b0), .seg_id_i(2'd0),
        .data_i(12'h000), .ready_and_o(a_ready), .en_o(a_en), .data_o(a_data_o),
        .written_o(a_written), .v_o(a_vo), .yumi_i(1'b0));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // seg0 = 8 bits at [7:0], seg1 = 4 bits at [11:8], seg2 = 12 bits at [23:12]
    function automatic logic [23:0] expd(input logic [11:0] d);
        return {d[11:0], d[3:0], d[7:0]};
    endfunction

    typedef struct { logic [2:0] en; logic [23:0] data; } exp_t;
    exp_t sb[$];

    // Scoreboard monitor: every enable pulse must match the queued expectation.
    always @(negedge clk_i) begin
        if (en_o != 3'b000 || sb.size() != 0) begin
            if (sb.size() == 0) begin
                chk("en_spurious", {29'd0, en_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("en", {29'd0, en_o}, {29'd0, e.en});
                chk("data", {8'd0, data_o}, {8'd0, e.data});
                chk("en_onehot", {31'd0, $countones(en_o) <= 1}, 32'd1);
            end
        end
    end

    task automatic wr(input logic [1:0] id, input logic [11:0] d,
                      input logic exp_rdy, input logic [2:0] exp_en);
        exp_t e;
        v_i = 1'b1; seg_id_i = id; data_i = d;
        if (exp_en != 3'b000) begin
            e.en = exp_en; e.data = expd(d); sb.push_back(e);
        end
        @(negedge clk_i);
        chk("ready", {31'd0, ready_and_o}, {31'd0, exp_rdy});
        @(posedge clk_i); #1;
        v_i = 1'b0;
    endtask

    task automatic state_chk(input string tag, input logic exp_v, input logic [2:0] exp_w);
        chk({tag, "_v"}, {31'd0, v_o}, {31'd0, exp_v});
        chk({tag, "_written"}, {29'd0, written_o}, {29'd0, exp_w});
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        @(negedge clk_i);
        chk("consume_v", {31'd0, v_o}, 32'd1);
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
        state_chk("cleared", 1'b0, 3'b000);
        chk("cleared_ready", {31'd0, ready_and_o}, 32'd1);
    endtask

    task automatic swr(input logic [1:0] id, input logic [11:0] d, input logic [2:0] exp_en);
        s_v = 1'b1; s_id = id; s_data = d;
        @(negedge clk_i);
        chk("skip_ready", {31'd0, s_ready}, 32'd1);
        chk("skip_en", {29'd0, s_en}, {29'd0, exp_en});
        chk("skip_data", {8'd0, s_data_o}, {8'd0, expd(d)});
        @(posedge clk_i); #1;
        s_v = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0;
        v_i = 1'b1; seg_id_i = 2'd0; data_i = 12'h05A; yumi_i = 1'b0;
        s_v = 1'b0; s_id = 2'd0; s_data = 12'h000; s_yumi = 1'b0;
        #2;
        // reset: outputs low even with a write presented
        chk("rst_en", {29'd0, en_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_and_o}, 32'd0);
        state_chk("rst", 1'b0, 3'b000);
        chk("rst_all_v", {31'd0, a_vo}, 32'd0);
        v_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rel_ready", {31'd0, ready_and_o}, 32'd1);
        state_chk("rel", 1'b0, 3'b000);
        chk("all_skip_full", {31'd0, a_vo}, 32'd1);
        chk("all_skip_ready", {31'd0, a_ready}, 32'd0);

        // 1: in-order fill
        wr(2'd0, 12'h0A5, 1'b1, 3'b001); state_chk("t1a", 1'b0, 3'b001);
        wr(2'd1, 12'h003, 1'b1, 3'b010); state_chk("t1b", 1'b0, 3'b011);
        wr(2'd2, 12'hBCD, 1'b1, 3'b100); state_chk("t1c", 1'b1, 3'b111);
        chk("t1_ready", {31'd0, ready_and_o}, 32'd0);

        // 2: writes blocked while FULL, then consume and accept
        for (int i = 0; i < 3; i++) begin
            wr(2'd0, 12'h011, 1'b0, 3'b000);
            state_chk("t2_hold", 1'b1, 3'b111);
        end
        consume();
        wr(2'd0, 12'h011, 1'b1, 3'b001); state_chk("t2a", 1'b0, 3'b001);
        wr(2'd1, 12'h00E, 1'b1, 3'b010);
        wr(2'd2, 12'h777, 1'b1, 3'b100); state_chk("t2b", 1'b1, 3'b111);
        consume();

        // 3: out of order with a duplicate
        wr(2'd2, 12'h123, 1'b1, 3'b100);
        wr(2'd0, 12'h044, 1'b1, 3'b001); state_chk("t3a", 1'b0, 3'b101);
`ifdef BSG_SEGMENT_ASSEMBLER_DUP_STALL_EN
        for (int i = 0; i < 3; i++) begin
            wr(2'd0, 12'h022, 1'b0, 3'b000);
            state_chk("t3_stall", 1'b0, 3'b101);
        end
`else
        wr(2'd0, 12'h022, 1'b1, 3'b001); state_chk("t3_dup", 1'b0, 3'b101);
`endif
        wr(2'd1, 12'h009, 1'b1, 3'b010); state_chk("t3b", 1'b1, 3'b111);
        consume();

        // 5: out-of-range id is accepted and discarded
        wr(2'd0, 12'h0F0, 1'b1, 3'b001);
        wr(2'd3, 12'hFFF, 1'b1, 3'b000); state_chk("t5", 1'b0, 3'b001);

        // 6: asynchronous reset mid-word
        wr(2'd1, 12'h005, 1'b1, 3'b010); state_chk("t6a", 1'b0, 3'b011);
        #3 reset_n_i = 1'b0;
        #1;
        state_chk("t6_rst", 1'b0, 3'b000);
        chk("t6_rst_ready", {31'd0, ready_and_o}, 32'd0);
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        wr(2'd0, 12'h0AA, 1'b1, 3'b001);
        wr(2'd1, 12'h00B, 1'b1, 3'b010); state_chk("t6b", 1'b0, 3'b011);
        wr(2'd2, 12'hCCC, 1'b1, 3'b100); state_chk("t6c", 1'b1, 3'b111);
        consume();
        chk("t6_all_v", {31'd0, a_vo}, 32'd1);

        // 4: skipped segment excluded from completion
        swr(2'd0, 12'h05C, 3'b001);
        chk("t4a_written", {29'd0, s_written}, 32'd1);
        swr(2'd1, 12'h00D, 3'b000);
        chk("t4b_written", {29'd0, s_written}, 32'd1);
        chk("t4b_v", {31'd0, s_vo}, 32'd0);
        swr(2'd2, 12'h3E1, 3'b100);
        chk("t4c_written", {29'd0, s_written}, 32'd5);
        chk("t4c_v", {31'd0, s_vo}, 32'd1);
        s_yumi = 1'b1;
        @(posedge clk_i); #1;
        s_yumi = 1'b0;
        chk("t4_cleared", {29'd0, s_written}, 32'd0);

        @(negedge clk_i);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
